// File: rtl/dmme_stage.sv
// Operand staging in front of a multiply core: an enable-gated input pipeline that drops zero-mask
// beats, a 2-entry result FIFO, and a per-job result counter that raises a done pulse.
module dmme_stage #(
  parameter int LANES    = 2,
  parameter int DW       = 64,
  parameter int CW       = 32,
  parameter int RCH      = 4,
  parameter int MW       = 4,
  parameter int IN_DEPTH = 1,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [LANES*DW-1:0]      ain,
  input  logic [LANES*DW-1:0]      bin,
  input  logic [MW-1:0]            maskin,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic                     core_mode,
  output logic [LANES*DW-1:0]      core_ain,
  output logic [LANES*DW-1:0]      core_bin,
  output logic [2*LANES*MW-1:0]    core_mask,
  input  logic                     core_res_valid,
  output logic                     core_res_ready,
  input  logic [RCH*CW-1:0]        core_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RCH*CW-1:0]        out_data,
  input  logic [CNT_W-1:0]         cnt_target,
  output logic                     done,
  output logic [CNT_W-1:0]         result_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int OW = LANES * DW;
  localparam int RW = RCH * CW;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                adv;
  logic [IN_DEPTH-1:0] stg_valid;
  logic [IN_DEPTH-1:0] stg_mode;
  logic [OW-1:0]       stg_a    [IN_DEPTH];
  logic [OW-1:0]       stg_b    [IN_DEPTH];
  logic [MW-1:0]       stg_mask [IN_DEPTH];

  assign adv      = en & (~core_valid | core_ready);
  assign in_ready = adv;

  // Payload loads on every advance; only the valid bit decides whether a beat exists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid <= '0;
      stg_mode  <= '0;
      for (int i = 0; i < IN_DEPTH; i++) begin
        stg_a[i]    <= '0;
        stg_b[i]    <= '0;
        stg_mask[i] <= '0;
      end
    end else if (adv) begin
      stg_valid[0] <= in_valid & (|maskin);
      stg_mode[0]  <= mode;
      stg_a[0]     <= ain;
      stg_b[0]     <= bin;
      stg_mask[0]  <= maskin;
      for (int i = 1; i < IN_DEPTH; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_mode[i]  <= stg_mode[i-1];
        stg_a[i]     <= stg_a[i-1];
        stg_b[i]     <= stg_b[i-1];
        stg_mask[i]  <= stg_mask[i-1];
      end
    end
  end

  assign core_valid = stg_valid[IN_DEPTH-1];
  assign core_mode  = stg_mode[IN_DEPTH-1];
  assign core_ain   = stg_a[IN_DEPTH-1];
  assign core_bin   = stg_b[IN_DEPTH-1];
  assign core_mask  = {(2*LANES){stg_mask[IN_DEPTH-1]}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (adv && in_valid && (maskin == '0) && (drop_count != CNT_MAX)) begin
      drop_count <= drop_count + CNT_ONE;
    end
  end

  logic [RW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;
  logic          push;
  logic          pop;

  // Ready depends only on occupancy, so a full FIFO refuses a push even while it is popping.
  assign core_res_ready = (occ != 2'd2);
  assign out_valid      = (occ != 2'd0);
  assign out_data       = fifo_mem[rd_ptr];
  assign push           = core_res_valid & core_res_ready;
  assign pop            = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= core_res;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        occ <= occ - 2'd1;
      end
    end
  end

  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = result_count + CNT_ONE;

  // A zero target never matches, so the count simply wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_count <= '0;
      done         <= 1'b0;
    end else if (pop) begin
      if ((cnt_target != '0) && (cnt_inc == cnt_target)) begin
        result_count <= '0;
        done         <= 1'b1;
      end else begin
        result_count <= cnt_inc;
        done         <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmme_stage.sv
// Scoreboard bench for dmme_stage: stimulus queues expected core beats and results, a negedge
// monitor pops and compares them and tracks the expected result_count/done sequence.
module tb_dmme_stage;

  localparam int LANES = 2;
  localparam int DW    = 64;
  localparam int CW    = 32;
  localparam int RCH   = 4;
  localparam int MW    = 4;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mode;
  logic [LANES*DW-1:0]   ain;
  logic [LANES*DW-1:0]   bin;
  logic [MW-1:0]         maskin;
  logic                  core_valid;
  logic                  core_ready;
  logic                  core_mode;
  logic [LANES*DW-1:0]   core_ain;
  logic [LANES*DW-1:0]   core_bin;
  logic [2*LANES*MW-1:0] core_mask;
  logic                  core_res_valid;
  logic                  core_res_ready;
  logic [RCH*CW-1:0]     core_res;
  logic                  out_valid;
  logic                  out_ready;
  logic [RCH*CW-1:0]     out_data;
  logic [CNT_W-1:0]      cnt_target;
  logic                  done;
  logic [CNT_W-1:0]      result_count;
  logic [CNT_W-1:0]      drop_count;

  dmme_stage dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .ain(ain), .bin(bin), .maskin(maskin), .core_valid(core_valid), .core_ready(core_ready),
    .core_mode(core_mode), .core_ain(core_ain), .core_bin(core_bin), .core_mask(core_mask),
    .core_res_valid(core_res_valid), .core_res_ready(core_res_ready), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cnt_target(cnt_target),
    .done(done), .result_count(result_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mode;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   m;
  } beat_t;

  beat_t        exp_beats[$];
  logic [127:0] exp_res[$];
  int           vecs = 0;
  int           errs = 0;
  int           done_seen = 0;
  logic [7:0]   exp_cnt = 8'd0;
  logic         exp_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: handshake never happened, got 0 expected 1", name);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic md, input logic [127:0] a, input logic [127:0] b,
                           input logic [3:0] m);
    bit ok = 0;
    in_valid = 1'b1; mode = md; ain = a; bin = b; maskin = m;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (m != 4'h0) exp_beats.push_back('{md, a, b, m});
        ok = 1;
      end
      sync();
    end
    in_valid = 1'b0;
    if (!ok) timeout("send_beat");
  endtask

  task automatic push_res(input logic [127:0] r);
    bit ok = 0;
    core_res_valid = 1'b1; core_res = r;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (core_res_ready) begin
        exp_res.push_back(r);
        ok = 1;
      end
      sync();
    end
    core_res_valid = 1'b0;
    if (!ok) timeout("push_res");
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_cnt  = 8'd0;
      exp_done = 1'b0;
    end else begin
      chk("done", done, exp_done);
      chk("result_count", result_count, exp_cnt);
      if (done) done_seen++;
      if (core_valid && core_ready && en) begin
        if (exp_beats.size() == 0) begin
          chk("core_unexpected_beat", 1'b1, 1'b0);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("core_ain", core_ain, e.a);
          chk("core_bin", core_bin, e.b);
          chk("core_mode", core_mode, e.mode);
          chk("core_mask", core_mask, {4{e.m}});
        end
      end
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) chk("out_unexpected_result", 1'b1, 1'b0);
        else chk("out_data", out_data, exp_res.pop_front());
        if (cnt_target != 8'd0 && exp_cnt + 8'd1 == cnt_target) begin
          exp_cnt  = 8'd0;
          exp_done = 1'b1;
        end else begin
          exp_cnt  = exp_cnt + 8'd1;
          exp_done = 1'b0;
        end
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; mode = 1'b0; ain = '0; bin = '0; maskin = '0;
    core_ready = 1'b1; core_res_valid = 1'b0; core_res = '0; out_ready = 1'b1; cnt_target = '0;

    @(negedge clk);
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_core_res_ready", core_res_ready, 1'b1);
    chk("rst_in_ready_en1", in_ready, 1'b1);
    chk("rst_drop_count", drop_count, 8'd0);
    chk("rst_result_count", result_count, 8'd0);
    en = 1'b0;
    #1 chk("rst_in_ready_en0", in_ready, 1'b0);
    en = 1'b1;
    sync();
    rst = 1'b1;
    sync();

    // single full-mask beat reaches the core one cycle after acceptance
    send_beat(1'b1, 128'h1, 128'hB0B, 4'hF);
    @(negedge clk);
    chk("lat_core_valid", core_valid, 1'b1);
    chk("lat_core_mask", core_mask, 16'hFFFF);
    chk("lat_core_ain", core_ain, 128'h1);
    sync();
    @(negedge clk);
    chk("lat_core_valid_gone", core_valid, 1'b0);
    sync();

    // zero-mask beats are dropped and counted with saturation
    send_beat(1'b0, 128'h5, 128'h6, 4'h0);
    @(negedge clk);
    chk("drop_core_valid", core_valid, 1'b0);
    chk("drop_count_1", drop_count, 8'd1);
    sync();
    for (int i = 0; i < 255; i++) send_beat(1'b0, 128'(i), 128'h0, 4'h0);
    @(negedge clk);
    chk("drop_count_256", drop_count, 8'd255);
    sync();
    send_beat(1'b0, 128'h7, 128'h7, 4'h0);
    @(negedge clk);
    chk("drop_count_sat", drop_count, 8'd255);
    sync();

    // core back-pressure holds the presented beat and blocks input
    core_ready = 1'b0;
    send_beat(1'b0, 128'hA1A1_0000_0000_0001, 128'hB1B1, 4'h3);
    @(negedge clk);
    chk("stall_core_valid", core_valid, 1'b1);
    chk("stall_in_ready", in_ready, 1'b0);
    sync();
    in_valid = 1'b1; mode = 1'b1; ain = 128'hA2A2; bin = 128'hB2B2; maskin = 4'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_in_ready_held", in_ready, 1'b0);
    chk("stall_core_ain_held", core_ain, 128'hA1A1_0000_0000_0001);
    chk("stall_core_bin_held", core_bin, 128'hB1B1);
    sync();
    core_ready = 1'b1;
    send_beat(1'b1, 128'hA2A2, 128'hB2B2, 4'h8);
    @(negedge clk);
    chk("release_core_ain", core_ain, 128'hA2A2);
    chk("release_core_mask", core_mask, 16'h8888);
    sync();

    // result FIFO fill, full-while-popping, ordered drain
    out_ready = 1'b0;
    push_res(128'h1000);
    push_res(128'h1001);
    core_res_valid = 1'b1; core_res = 128'h1002;
    @(negedge clk);
    chk("full_core_res_ready", core_res_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_out_data_head", out_data, 128'h1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("full_out_data_stable", out_data, 128'h1000);
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_core_res_ready", core_res_ready, 1'b0);
    sync();
    push_res(128'h1002);
    repeat (2) @(negedge clk);
    chk("drain_result_count", result_count, 8'd3);
    chk("drain_out_valid", out_valid, 1'b0);
    sync();

    // mid-job target change, then a 3-result job
    cnt_target = 8'd5;
    push_res(128'h2000);
    push_res(128'h2001);
    repeat (3) sync();
    cnt_target = 8'd3;
    push_res(128'h3000);
    push_res(128'h3001);
    push_res(128'h3002);
    repeat (2) @(negedge clk);
    chk("job_done_pulse", done, 1'b1);
    chk("job_result_count", result_count, 8'd0);
    @(negedge clk);
    chk("job_done_one_cycle", done, 1'b0);
    sync();
    chk("done_pulses", done_seen, 2);

    // reset with buffered results and an in-flight beat
    cnt_target = 8'd2;
    out_ready = 1'b0;
    push_res(128'h4000);
    push_res(128'h4001);
    core_ready = 1'b0;
    send_beat(1'b0, 128'hA3, 128'hB3, 4'h1);
    sync();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_core_valid", core_valid, 1'b0);
    chk("mid_rst_drop_count", drop_count, 8'd0);
    chk("mid_rst_result_count", result_count, 8'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_core_res_ready", core_res_ready, 1'b1);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    exp_beats.delete();
    exp_res.delete();
    sync();
    rst = 1'b1; out_ready = 1'b1; core_ready = 1'b1;
    repeat (5) sync();
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_core_valid", core_valid, 1'b0);
    chk("post_rst_no_done", done_seen, 2);
    chk("beats_left", exp_beats.size(), 0);
    chk("results_left", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dmme_stage.md
DMME_STAGE -- requirements
Module: dmme_stage

Interface
REQ-001 SHALL have parameter LANES, default 2: operand lanes per side (A, B).
REQ-002 SHALL have parameter DW, default 64: operand lane width.
REQ-003 SHALL have parameter CW, default 32: result channel width.
REQ-004 SHALL have parameter RCH, default 4: result channels per beat.
REQ-005 SHALL have parameter MW, default 4: mask width.
REQ-006 SHALL have parameter IN_DEPTH, default 1, legal range 1..4: input register stages.
REQ-007 SHALL have parameter CNT_W, default 8: result/drop counter width.
REQ-008 SHALL have these ports:
 clk  in  1  single clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 en  in  1  input-pipeline enable
 in_valid  in  1  input beat valid
 in_ready  out  1  input beat accepted when in_valid&in_ready
 mode  in  1  per-beat mode
 ain  in  LANES*DW  A operands
 bin  in  LANES*DW  B operands
 maskin  in  MW  beat mask
 core_valid  out  1  beat presented to core
 core_ready  in  1  core accepts beat
 core_mode  out  1  mode of presented beat
 core_ain  out  LANES*DW  A operands to core
 core_bin  out  LANES*DW  B operands to core
 core_mask  out  2*LANES*MW  mask copies, one per A/B lane
 core_res_valid  in  1  core result valid
 core_res_ready  out  1  stage can take result
 core_res  in  RCH*CW  core result channels
 out_valid  out  1  result available
 out_ready  in  1  downstream accepts result
 out_data  out  RCH*CW  result channels
 cnt_target  in  CNT_W  results per job; 0 = never done
 done  out  1  one-cycle job-complete pulse
 result_count  out  CNT_W  results popped in current job
 drop_count  out  CNT_W  masked beats dropped, saturating

Function
REQ-009 SHALL compute adv = en & (~core_valid | core_ready); in_ready SHALL equal adv (combinational).
REQ-010 When adv=1, the IN_DEPTH-stage pipeline SHALL shift one stage, each stage carrying {valid, mode, ain, bin, mask}; when adv=0, all stages SHALL hold.
REQ-011 Stage 0 SHALL load valid = in_valid & (maskin != 0) on adv; a beat with maskin==0 that is accepted SHALL not be forwarded.
REQ-012 Each accepted zero-mask beat SHALL increment drop_count by 1, saturating at 2^CNT_W-1.
REQ-013 core_valid/core_mode/core_ain/core_bin SHALL be driven from the last stage; unstalled latency from acceptance to core_valid = IN_DEPTH cycles.
REQ-014 core_mask SHALL be 2*LANES replicated copies of the last-stage mask.
REQ-015 Output path SHALL be a 2-entry FIFO; core_res_ready = (occupancy < 2), combinational from occupancy.
REQ-016 Push on core_res_valid & core_res_ready; pop on out_valid & out_ready; simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-017 out_valid = (occupancy != 0); out_data = head entry; out_data SHALL stay stable while out_valid & ~out_ready.
REQ-018 At occupancy 2 with a pop in the same cycle, core_res_ready SHALL still be 0 (no push that cycle).
REQ-019 en SHALL gate only the input pipeline; the FIFO, result_count and done SHALL operate regardless of en.
REQ-020 Each pop SHALL increment result_count; when the incremented value equals cnt_target (nonzero), done SHALL pulse 1 on the next cycle and result_count SHALL clear to 0 in the same update.
REQ-021 With cnt_target=0, result_count SHALL wrap modulo 2^CNT_W and done SHALL stay 0.
REQ-022 A cnt_target change mid-job SHALL take effect at the next pop comparison.

Reset
REQ-023 rst=0 SHALL asynchronously clear all pipeline valids, payloads, FIFO occupancy/entries, result_count, drop_count and done to 0.
REQ-024 During reset: core_valid=0, out_valid=0, done=0, core_res_ready=1, in_ready=en.
REQ-025 Reset mid-job SHALL discard in-flight beats and buffered results with no done pulse.

Verification
REQ-026 Defaults, en=1, core_ready=1, one beat maskin=4'hF, ain=64'h1 -> core_valid=1 exactly 1 cycle later, core_mask=16'hFFFF.
REQ-027 Beat with maskin=0 -> core_valid stays 0, drop_count=1; 256 such beats -> drop_count=255.
REQ-028 core_ready=0 with core_valid=1 -> in_ready=0 and core_ain held; release -> next beat advances.
REQ-029 out_ready=0, push results R0,R1 -> core_res_ready=0; out_ready=1 -> R0 then R1 popped in order.
REQ-030 cnt_target=3, pop 3 results -> done=1 for one cycle after 3rd pop, result_count=0.
REQ-031 rst pulsed low with 2 buffered results and 1 in-flight beat -> out_valid=0, core_valid=0, counters 0, no done.
